serial_tx_scheduler: RTL and testbench

//  Shares the single asynchronous serial transmitter (load / parallel-to-serial shifter / bit-count done)

---
 rtl/serial_pkg.sv | 28 ++
 rtl/serial_tx_scheduler_if.sv | 32 +++
 rtl/serial_tx_scheduler_rr_arbiter.sv | 44 ++++
 rtl/serial_tx_scheduler.sv | 169 ++++++++++++++++
 tb/tb_serial_tx_scheduler.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit scheduler.
//   state_e    : scheduler FSM encoding
//   FRAME_BITS : bits per frame on the line (start + 8 data + stop)
//   BYTE_W     : payload width
//   ID_W       : requester index width (covers up to 8 requesters)
package serial_pkg;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned ID_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // Round-robin successor of a requester index, wrapping at nreq.
  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] idx,
                                               input int unsigned     nreq);
    if (32'(idx) + 32'd1 >= nreq) begin
      return '0;
    end
    return idx + ID_W'(1);
  endfunction

endpackage

// File: rtl/serial_tx_scheduler_if.sv
// Bundle between the requesters / transmit datapath and the scheduler.
//   master : requester + shifter side (drives req, req_data, tx_sent, err_clr)
//   slave  : scheduler side (drives acks, dones, grant, shifter controls, error)
interface serial_tx_scheduler_if #(
  parameter int unsigned NREQ = 4
);
  import serial_pkg::*;

  logic [NREQ-1:0]        req;
  logic [BYTE_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]        req_ack;
  logic [NREQ-1:0]        req_done;
  logic [ID_W-1:0]        grant_id;
  logic                   busy;
  logic                   tx_load;
  logic [BYTE_W-1:0]      tx_data;
  logic                   tx_enable;
  logic                   tx_sent;
  logic                   err_clr;
  logic                   timeout_err;

  modport master (
    output req, req_data, tx_sent, err_clr,
    input  req_ack, req_done, grant_id, busy, tx_load, tx_data, tx_enable, timeout_err
  );

  modport slave (
    input  req, req_data, tx_sent, err_clr,
    output req_ack, req_done, grant_id, busy, tx_load, tx_data, tx_enable, timeout_err
  );

endinterface

// File: rtl/serial_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i (wrapping).
//   req_i   : request vector
//   ptr_i   : highest-priority index (must be < NREQ)
//   gnt_o   : one-hot grant
//   idx_o   : granted index
//   valid_o : some request was found
module rr_arbiter
  import serial_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] idx_o,
  output logic            valid_o
);

  logic [2*NREQ-1:0] req2_c;
  logic [NREQ-1:0]   rot_c;
  int unsigned       sum_c;

  // Rotate so bit 0 is the pointer position, then take the lowest set bit.
  always_comb begin
    req2_c  = {req_i, req_i} >> ptr_i;
    rot_c   = req2_c[NREQ-1:0];
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    sum_c   = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      if (!valid_o && rot_c[off]) begin
        valid_o = 1'b1;
        sum_c   = 32'(ptr_i) + off;
        if (sum_c >= NREQ) begin
          sum_c = sum_c - NREQ;
        end
        idx_o = ID_W'(sum_c);
        gnt_o = NREQ'(1) << idx_o;
      end
    end
  end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Shares one asynchronous serial transmitter among NREQ byte requesters.
// Round-robin accept -> LOAD (shifter load pulse) -> SEND (enable until frame-sent
// edge or timeout) -> GAP (idle line) -> IDLE.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : requester handshake, shifter controls, frame-sent flag, error flag
module serial_tx_scheduler
  import serial_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned GAP_CYC     = 16,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                clk,
  input  logic                rst,
  serial_tx_scheduler_if.slave bus
);

  localparam int unsigned TO_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned TO_LAST  = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam int unsigned GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              load_q, load_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

  logic              sync1_q, sync2_q, sent_prev_q;
  logic              sent_edge_c;

  logic [NREQ-1:0]   arb_gnt_c;
  logic [ID_W-1:0]   arb_idx_c;
  logic              arb_valid_c;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt_c),
    .idx_o   (arb_idx_c),
    .valid_o (arb_valid_c)
  );

  // Frame-sent flag comes from a slow foreign domain: two-flop sync, then rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sent_prev_q <= 1'b0;
    end else begin
      sync1_q     <= bus.tx_sent;
      sync2_q     <= sync1_q;
      sent_prev_q <= sync2_q;
    end
  end

  assign sent_edge_c = sync2_q & ~sent_prev_q;

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      ack_q      <= '0;
      done_q     <= '0;
      data_q     <= '0;
      load_q     <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      data_q     <= data_d;
      load_q     <= load_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      to_cnt_q   <= to_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    ack_d      = '0;
    done_d     = '0;
    data_d     = data_q;
    load_d     = 1'b0;
    en_d       = 1'b0;
    to_cnt_d   = to_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    err_d      = err_q;

    // A timeout below overrides a clear in the same cycle.
    if (bus.err_clr) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid_c) begin
          ack_d      = arb_gnt_c;
          grant_id_d = arb_idx_c;
          data_d     = BYTE_W'(bus.req_data >> (BYTE_W * 32'(arb_idx_c)));
          ptr_d      = rr_next(arb_idx_c, NREQ);
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_d   = 1'b1;
        to_cnt_d = '0;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (sent_edge_c) begin
          done_d    = NREQ'(1) << grant_id_q;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else if (to_cnt_q == TO_W'(TO_LAST)) begin
          err_d     = 1'b1;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else begin
          en_d = 1'b1;
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + GAP_W'(1);
        // GAP_CYC of 0 still spends one cycle here.
        if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d != ST_IDLE);

  assign bus.req_ack     = ack_q;
  assign bus.req_done    = done_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.busy        = busy_q;
  assign bus.tx_load     = load_q;
  assign bus.tx_data     = data_q;
  assign bus.tx_enable   = en_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Directed bench for serial_tx_scheduler (NREQ=4, GAP_CYC=4, TIMEOUT_CYC=100).
module tb_serial_tx_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  serial_tx_scheduler_if #(.NREQ(4)) bus ();

  serial_tx_scheduler #(
    .NREQ        (4),
    .GAP_CYC     (4),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Wait for the next ack and check which requester and byte were taken.
  task automatic wait_ack(input string tag, input logic [3:0] want_ack, input logic [7:0] want_data);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.req_ack == 4'd0 && n < 30);
    check({tag, "_ack"}, 32'(bus.req_ack), 32'(want_ack));
    check({tag, "_data"}, 32'(bus.tx_data), 32'(want_data));
  endtask

  // Let the frame run a few cycles, signal frame sent, check done, wait for idle.
  task automatic finish_frame(input string tag, input logic [3:0] want_done);
    int n;
    repeat (3) tick();
    #3 bus.tx_sent = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.req_done == 4'd0 && n < 20);
    check({tag, "_done"}, 32'(bus.req_done), 32'(want_done));
    #3 bus.tx_sent = 1'b0;
    n = 0;
    while (bus.busy && n < 30) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    int dones;
    bus.req      = '0;
    bus.req_data = {8'h44, 8'h33, 8'hA5, 8'h11};
    bus.tx_sent  = 1'b0;
    bus.err_clr  = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_txen", 32'(bus.tx_enable), 32'd0);
    check("rst_data", 32'(bus.tx_data), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_ack", 32'(bus.req_ack), 32'd0);
    check("idle_err", 32'(bus.timeout_err), 32'd0);

    // Single request: ack one clock after req, load, then enable.
    bus.req = 4'b0010;
    tick();
    check("s_ack", 32'(bus.req_ack), 32'h2);
    check("s_gid", 32'(bus.grant_id), 32'd1);
    check("s_data", 32'(bus.tx_data), 32'hA5);
    check("s_busy", 32'(bus.busy), 32'd1);
    check("s_load0", 32'(bus.tx_load), 32'd0);
    bus.req = 4'b0000;
    bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    tick();
    check("s_load", 32'(bus.tx_load), 32'd1);
    check("s_en0", 32'(bus.tx_enable), 32'd0);
    tick();
    check("s_load_end", 32'(bus.tx_load), 32'd0);
    check("s_en", 32'(bus.tx_enable), 32'd1);
    repeat (5) tick();
    check("s_en_hold", 32'(bus.tx_enable), 32'd1);
    check("s_data_hold", 32'(bus.tx_data), 32'hA5);
    #3 bus.tx_sent = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.req_done == 4'd0 && n < 20);
    check("s_done", 32'(bus.req_done), 32'h2);
    check("s_en_off", 32'(bus.tx_enable), 32'd0);
    n = 0;
    while (bus.busy && n < 30) begin
      tick();
      n++;
    end
    check("s_gap_len", 32'(n), 32'd4);
    bus.tx_sent = 1'b0;
    repeat (3) tick();

    // Fairness from pointer 0 with all four requesting continuously.
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    bus.req = 4'b1111;
    wait_ack("f0", 4'b0001, 8'h11); finish_frame("f0", 4'b0001);
    wait_ack("f1", 4'b0010, 8'h22); finish_frame("f1", 4'b0010);
    wait_ack("f2", 4'b0100, 8'h33); finish_frame("f2", 4'b0100);
    wait_ack("f3", 4'b1000, 8'h44); finish_frame("f3", 4'b1000);
    wait_ack("f4", 4'b0001, 8'h11); finish_frame("f4", 4'b0001);
    wait_ack("f5", 4'b0010, 8'h22); finish_frame("f5", 4'b0010);

    // Wrap: grant 2 moves the pointer to 3, then 0 and 1 pend.
    bus.req = 4'b0100;
    wait_ack("w2", 4'b0100, 8'h33);
    bus.req = 4'b0011;
    finish_frame("w2", 4'b0100);
    wait_ack("w0", 4'b0001, 8'h11); finish_frame("w0", 4'b0001);
    wait_ack("w1", 4'b0010, 8'h22);
    bus.req = 4'b0000;
    finish_frame("w1", 4'b0010);

    // Timeout: pointer is 2, only requester 3 asks; tx_sent never rises.
    bus.req = 4'b1000;
    wait_ack("t3", 4'b1000, 8'h44);
    bus.req = 4'b0001;
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.req_done != 4'd0) dones++;
    end
    check("t_err_early", 32'(bus.timeout_err), 32'd0);
    check("t_en_last", 32'(bus.tx_enable), 32'd1);
    tick();
    if (bus.req_done != 4'd0) dones++;
    check("t_err", 32'(bus.timeout_err), 32'd1);
    check("t_en_off", 32'(bus.tx_enable), 32'd0);
    check("t_no_done", 32'(dones), 32'd0);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.req_ack == 4'd0 && n < 30);
    check("t_next_lat", 32'(n), 32'd5);
    check("t_next_ack", 32'(bus.req_ack), 32'h1);
    bus.req = 4'b0000;
    finish_frame("t0", 4'b0001);
    check("t_sticky", 32'(bus.timeout_err), 32'd1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("t_clr", 32'(bus.timeout_err), 32'd0);

    // Reset in SEND clears outputs at once and the pointer returns to 0.
    bus.req = 4'b0100;
    wait_ack("r2", 4'b0100, 8'h33);
    bus.req = 4'b0000;
    repeat (2) tick();
    check("r_en_pre", 32'(bus.tx_enable), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("r_en", 32'(bus.tx_enable), 32'd0);
    check("r_busy", 32'(bus.busy), 32'd0);
    check("r_gid", 32'(bus.grant_id), 32'd0);
    check("r_data", 32'(bus.tx_data), 32'd0);
    #3 rst = 1'b0;
    tick();
    bus.req = 4'b1111;
    wait_ack("r_ptr", 4'b0001, 8'h11);
    bus.req = 4'b0000;
    finish_frame("r0", 4'b0001);

    // Short asynchronous frame-sent pulse gives exactly one done.
    bus.req = 4'b0010;
    wait_ack("y1", 4'b0010, 8'h22);
    bus.req = 4'b0000;
    repeat (4) tick();
    #3 bus.tx_sent = 1'b1;
    #23 bus.tx_sent = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.req_done != 4'd0) dones++;
    end
    check("y_pulse_dones", 32'(dones), 32'd1);

    // Level held high: one done, none for the following frame until a new edge.
    bus.req = 4'b0100;
    wait_ack("y2", 4'b0100, 8'h33);
    bus.req = 4'b0001;
    repeat (3) tick();
    #3 bus.tx_sent = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.req_done != 4'd0) dones++;
    end
    check("y_level_dones", 32'(dones), 32'd1);
    check("y_next_ack_pending", 32'(bus.busy), 32'd1);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.req_done != 4'd0) dones++;
    end
    check("y_no_repeat", 32'(dones), 32'd0);
    check("y_gid", 32'(bus.grant_id), 32'd0);
    bus.req = 4'b0000;
    bus.tx_sent = 1'b0;
    repeat (4) tick();
    #3 bus.tx_sent = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.req_done == 4'd0 && n < 20);
    check("y_done_after_edge", 32'(bus.req_done), 32'h1);
    bus.tx_sent = 1'b0;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
